// File: rtl/period_meter.sv
// Measures rising-to-rising period and high time of an asynchronous input in clk cycles.
// Optional build macro PERIOD_METER_AVG_EN reports the mean of every 4 completed periods.
module period_meter #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 2500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, hist_q;
  logic             rise;
  logic             at_limit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hicnt_q, hicnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;

`ifdef PERIOD_METER_AVG_EN
  logic [CNT_W+1:0] accp_q, accp_d;
  logic [CNT_W+1:0] acch_q, acch_d;
  logic [CNT_W+1:0] sum_p, sum_h;
  logic [1:0]       nper_q, nper_d;

  assign sum_p = accp_q + (CNT_W+2)'(cnt_q);
  assign sum_h = acch_q + (CNT_W+2)'(hicnt_q);
`endif

  assign rise     = sync2_q & ~hist_q;
  assign at_limit = (cnt_q == TIMEOUT_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      hicnt_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      accp_q   <= '0;
      acch_q   <= '0;
      nper_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync1_q  <= sig_in;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      cnt_q    <= cnt_d;
      hicnt_q  <= hicnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
`ifdef PERIOD_METER_AVG_EN
      accp_q   <= accp_d;
      acch_q   <= acch_d;
      nper_q   <= nper_d;
`endif
    end
  end

  // A rise coinciding with the timeout limit completes the period instead of stalling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, STALLED: if (rise) state_d = MEASURE;
      MEASURE:       if (!rise && at_limit) state_d = STALLED;
      default:       state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    hicnt_d  = hicnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tout_d   = tout_q;
`ifdef PERIOD_METER_AVG_EN
    accp_d   = accp_q;
    acch_d   = acch_q;
    nper_d   = nper_q;
`endif
    case (state_q)
      IDLE, STALLED: begin
        cnt_d   = rise ? ONE_C : '0;
        hicnt_d = rise ? ONE_C : '0;
      end
      MEASURE: begin
        if (rise) begin
          cnt_d   = ONE_C;
          hicnt_d = ONE_C;
`ifdef PERIOD_METER_AVG_EN
          if (nper_q == 2'd3) begin
            period_d = CNT_W'(sum_p >> 2);
            high_d   = CNT_W'(sum_h >> 2);
            valid_d  = 1'b1;
            tout_d   = 1'b0;
            accp_d   = '0;
            acch_d   = '0;
            nper_d   = '0;
          end else begin
            accp_d   = sum_p;
            acch_d   = sum_h;
            nper_d   = nper_q + 2'd1;
          end
`else
          period_d = cnt_q;
          high_d   = hicnt_q;
          valid_d  = 1'b1;
          tout_d   = 1'b0;
`endif
        end else if (at_limit) begin
          cnt_d    = '0;
          hicnt_d  = '0;
          period_d = '0;
          high_d   = '0;
          tout_d   = 1'b1;
`ifdef PERIOD_METER_AVG_EN
          accp_d   = '0;
          acch_d   = '0;
          nper_d   = '0;
`endif
        end else begin
          cnt_d   = cnt_q + ONE_C;
          hicnt_d = hicnt_q + CNT_W'(sync2_q);
        end
      end
      default: begin
        cnt_d   = '0;
        hicnt_d = '0;
      end
    endcase
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign timeout      = tout_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter: timestamp-based reference model compared every cycle,
// plus literal checks of known waveforms. Honours PERIOD_METER_AVG_EN like the design.
`timescale 1ns/1ps
module tb_period_meter;
  localparam int unsigned CNT_W = 16;
`ifdef PERIOD_METER_AVG_EN
  localparam int unsigned TIMEOUT = 2000;
  localparam bit AVG = 1'b1;
`else
  localparam int unsigned TIMEOUT = 1000;
  localparam bit AVG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             period_valid, timeout;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the input is seen through a 3-sample delay; periods are rise timestamps
  // differences and high time is the count of high samples between them.
  bit d1, d2, d3;
  bit meas;
  int last_rise;
  int k = 0;
  bit sh [0:131071];
  int m_p = 0, m_h = 0;
  bit m_v = 1'b0, m_t = 1'b0;
  int hp, hh;
  bit r, s;
  int qp[$], qh[$];
  int strobes = 0;
  int last_sp = 0, last_sh = 0;

  task automatic model_complete(input int p, input int h);
    if (AVG) begin
      qp.push_back(p);
      qh.push_back(h);
      if (qp.size() == 4) begin
        m_p = qp.sum() / 4;
        m_h = qh.sum() / 4;
        m_v = 1'b1;
        m_t = 1'b0;
        qp.delete();
        qh.delete();
      end
    end else begin
      m_p = p;
      m_h = h;
      m_v = 1'b1;
      m_t = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      d1 = 0; d2 = 0; d3 = 0;
      meas = 0;
      m_p = 0; m_h = 0; m_v = 0; m_t = 0;
      qp.delete(); qh.delete();
    end else begin
      s = d2;
      r = d2 & ~d3;
      sh[k] = s;
      m_v = 1'b0;
      if (meas && r) begin
        hp = k - last_rise;
        hh = 0;
        for (int j = last_rise; j < k; j++) hh += int'(sh[j]);
        model_complete(hp, hh);
        last_rise = k;
      end else if (meas && (k - last_rise == int'(TIMEOUT))) begin
        meas = 0;
        m_p = 0; m_h = 0; m_t = 1'b1;
        qp.delete(); qh.delete();
      end else if (!meas && r) begin
        meas = 1;
        last_rise = k;
      end
      d3 = d2; d2 = d1; d1 = sig_in;
    end
    k++;
    #1;
    chk("period", period, m_p);
    chk("high_time", high_time, m_h);
    chk("period_valid", period_valid, m_v);
    chk("timeout", timeout, m_t);
    if (period_valid === 1'b1) begin
      strobes++;
      last_sp = int'(period);
      last_sh = int'(high_time);
    end
  end

  task automatic seg(input bit lvl, input int n);
    sig_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int p, input int h, input int reps);
    repeat (reps) begin
      seg(1'b1, h);
      seg(1'b0, p - h);
    end
  endtask

  int s0;
  int p, h, kind, reps;

  initial begin
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period", period, 0);
    chk("reset_high", high_time, 0);
    chk("reset_valid", period_valid, 0);
    chk("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    seg(1'b0, 10);

    s0 = strobes;
    if (AVG) begin
      seg(1, 500); seg(0, 500);
      seg(1, 500); seg(0, 502);
      seg(1, 500); seg(0, 504);
      seg(1, 500); seg(0, 506);
      seg(1, 500); seg(0, 20);
      chk("avg_strobes", strobes - s0, 1);
      chk("avg_period", last_sp, 1003);
      chk("avg_high", last_sh, 500);
    end else begin
      // period equal to TIMEOUT: the rise lands on the limit and must still count
      wave(1000, 300, 5);
      chk("p1000_strobes", strobes - s0, 4);
      chk("p1000_period", last_sp, 1000);
      chk("p1000_high", last_sh, 300);
    end
    chk("p1000_timeout", timeout, 0);

    seg(1'b0, TIMEOUT + 100);
    chk("stuck_low_timeout", timeout, 1);
    chk("stuck_low_period", period, 0);
    chk("stuck_low_high", high_time, 0);

    s0 = strobes;
    wave(1000, 500, AVG ? 6 : 3);
    chk("restart_strobes", strobes - s0, AVG ? 1 : 2);
    chk("restart_timeout", timeout, 0);
    chk("restart_period", last_sp, 1000);

    wave(1000, 300, 2);
    seg(1'b1, 200);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_period", period, 0);
    chk("async_rst_high", high_time, 0);
    chk("async_rst_valid", period_valid, 0);
    chk("async_rst_timeout", timeout, 0);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seg(1'b0, 50);
    s0 = strobes;
    wave(800, 200, 2);
    chk("post_rst_strobes", strobes - s0, AVG ? 0 : 1);
    if (!AVG) begin
      chk("post_rst_period", last_sp, 800);
      chk("post_rst_high", last_sh, 200);
    end

    seg(1'b1, TIMEOUT + 200);
    chk("stuck_high_timeout", timeout, 1);
    seg(1'b0, 20);

    repeat (30) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        seg(1'($urandom_range(0, 1)), TIMEOUT + $urandom_range(0, 300));
      end else if (kind <= 3) begin
        p = TIMEOUT - 2 + $urandom_range(0, 4);
        h = $urandom_range(1, p - 1);
        wave(p, h, $urandom_range(1, 2));
      end else begin
        p = $urandom_range(2, TIMEOUT + 50);
        h = $urandom_range(1, p - 1);
        reps = $urandom_range(1, 3);
        wave(p, h, reps);
      end
    end
    seg(1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(40 * 125000);
    n_bad++;
    $display("FAIL watchdog: got timeout at %0t expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter: CNT_W, default 24, width of period/high-time counters and outputs.
REQ-002 Parameter: TIMEOUT, default 2500000, max clk cycles between rising edges before timeout (100 ms at 25 MHz); SHALL satisfy 2 <= TIMEOUT < 2^CNT_W.
REQ-003 Port: clk  input  1  system clock, 25 MHz, all logic on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: sig_in  input  1  asynchronous periodic input (e.g. divided slow clock), unrelated to clk.
REQ-006 Port: period  output  CNT_W  last measured rising-to-rising period in clk cycles.
REQ-007 Port: high_time  output  CNT_W  clk cycles sig_in was high within that period.
REQ-008 Port: period_valid  output  1  single-cycle strobe, period/high_time updated this cycle.
REQ-009 Port: timeout  output  1  level, no rising edge seen within TIMEOUT cycles.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer plus one history flop; rise = sync & ~hist, so detection lags the input edge by 3 clk.
REQ-011 FSM states: IDLE, MEASURE, STALLED.
REQ-012 IDLE (after reset): cnt and hi_cnt held 0; on rise -> MEASURE, cnt<=1, hi_cnt<=1.
REQ-013 MEASURE: cnt increments by 1 each cycle; hi_cnt increments each cycle sync is high.
REQ-014 MEASURE, on rise: period<=cnt, high_time<=hi_cnt, period_valid=1 next cycle for exactly 1 clk, cnt<=1, hi_cnt<=1, timeout<=0.
REQ-015 MEASURE, cnt==TIMEOUT without rise: -> STALLED, timeout<=1, period and high_time<=0, no period_valid.
REQ-016 Rise in the same cycle as cnt==TIMEOUT: rise wins, REQ-014 applies, no timeout.
REQ-017 STALLED: counters held 0; on rise -> MEASURE, cnt<=1, hi_cnt<=1; timeout stays 1 until the next period_valid.
REQ-018 First rise after IDLE or STALLED SHALL NOT produce period_valid (no complete period).
REQ-019 Counters SHALL never wrap; TIMEOUT bound guarantees cnt < 2^CNT_W.
REQ-020 A constant-high or constant-low sig_in SHALL reach STALLED via REQ-015.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, synchronizer/history flops 0, cnt=0, hi_cnt=0, period=0, high_time=0, period_valid=0, timeout=0.
REQ-022 Reset asserted mid-measurement SHALL discard the partial period; after release the first rise re-enters MEASURE per REQ-012 with no strobe.
REQ-023 Reset release is synchronised to clk by the system; the block needs no further deassertion handling.

Configuration
REQ-024 Macro PERIOD_METER_AVG_EN defined: period and high_time SHALL be the mean of 4 consecutive measurements (sum in CNT_W+2-bit accumulators, output = sum>>2, truncated); period_valid fires on every 4th completed period; accumulators and period-count clear on reset and on entry to STALLED.
REQ-025 Macro PERIOD_METER_AVG_EN undefined: no accumulators; outputs update and period_valid fires on every completed period per REQ-014.

Verification
REQ-026 sig_in 100 Hz, 50% duty (toggle every 125000 clk), averaging off -> after 2nd rise, period=250000, high_time=125000, period_valid 1-clk pulse once per 250000 clk, timeout=0.
REQ-027 sig_in period 1000 clk, high 300 clk -> period=1000, high_time=300 every period; first rise yields no strobe.
REQ-028 sig_in stuck low after valid measurements -> exactly TIMEOUT clk after last detected rise: timeout=1, period=0, high_time=0; restart toggling at 1000 clk period -> timeout clears with first period_valid, period=1000.
REQ-029 rst_n pulsed low mid-period -> all outputs 0 immediately; next two rises give one strobe with a full correct period.
REQ-030 PERIOD_METER_AVG_EN defined, periods 1000,1002,1004,1006 clk -> single strobe after 4th, period=1003; no strobe on the first three.
REQ-031 Rise arriving exactly when cnt==TIMEOUT (set TIMEOUT=1000, period 1000) -> period_valid with period=1000, timeout stays 0.
